// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default width for the
// multicycle ALU and its iterative multiply/divide unit.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [4:0] ALUOP_ADD    = 5'd0;
    localparam logic [4:0] ALUOP_SUB    = 5'd1;
    localparam logic [4:0] ALUOP_AND    = 5'd2;
    localparam logic [4:0] ALUOP_OR     = 5'd3;
    localparam logic [4:0] ALUOP_XOR    = 5'd4;
    localparam logic [4:0] ALUOP_SLL    = 5'd5;
    localparam logic [4:0] ALUOP_SRL    = 5'd6;
    localparam logic [4:0] ALUOP_SRA    = 5'd7;
    localparam logic [4:0] ALUOP_NON    = 5'd8;
    localparam logic [4:0] ALUOP_SLT    = 5'd9;
    localparam logic [4:0] ALUOP_SLTU   = 5'd10;
    localparam logic [4:0] ALUOP_MUL    = 5'd16;
    localparam logic [4:0] ALUOP_MULH   = 5'd17;
    localparam logic [4:0] ALUOP_MULHSU = 5'd18;
    localparam logic [4:0] ALUOP_MULHU  = 5'd19;
    localparam logic [4:0] ALUOP_DIV    = 5'd20;
    localparam logic [4:0] ALUOP_DIVU   = 5'd21;
    localparam logic [4:0] ALUOP_REM    = 5'd22;
    localparam logic [4:0] ALUOP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } alu_state_e;

    // Codes 16..23 are the iterative multiply/divide group.
    function automatic logic aluop_is_iter(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide on operand magnitudes: one shift-add or restoring
// step per cycle over a 2*XLEN accumulator, sign fix applied to the output.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              a_sgn, b_sgn;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   q_mag, r_mag;

    // done_o marks the cycle in which the final iteration is being applied.
    assign done_o = active_q && (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op_i)
            ALUOP_MULH, ALUOP_DIV, ALUOP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            ALUOP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, b_mag_q};
        if (op_q[2]) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!div_trial[XLEN])
                step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
                step = {acc_q[2*XLEN-2:0], 1'b0};
        end else if (acc_q[0]) begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            step = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    always_comb begin
        op_d     = op_q;
        a_raw_d  = a_raw_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        if (start_i) begin
            op_d     = op_i;
            a_raw_d  = a_i;
            a_neg_d  = a_sgn & a_i[XLEN-1];
            b_neg_d  = b_sgn & b_i[XLEN-1];
            b_mag_d  = b_neg_d ? -b_i : b_i;
            acc_d    = {{XLEN{1'b0}}, (a_neg_d ? -a_i : a_i)};
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (done_o)
                active_d = 1'b0;
        end
    end

    // Most-negative / -1 needs no special path: the magnitude quotient
    // negates back to most-negative and the remainder is already zero.
    always_comb begin
        prod  = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        q_mag = acc_q[XLEN-1:0];
        r_mag = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            ALUOP_MUL:
                result_o = prod[XLEN-1:0];
            ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU:
                result_o = prod[2*XLEN-1:XLEN];
            ALUOP_DIV, ALUOP_DIVU:
                result_o = (b_mag_q == '0) ? '1 : ((a_neg_q ^ b_neg_q) ? -q_mag : q_mag);
            ALUOP_REM, ALUOP_REMU:
                result_o = (b_mag_q == '0) ? a_raw_q : (a_neg_q ? -r_mag : r_mag);
            default:
                result_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= ALUOP_MUL;
            a_raw_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_raw_q  <= a_raw_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multicycle RV32I/M ALU: single-cycle datapath, valid/ready handshake and
// registered result/zero; multiply/divide delegated to alu_muldiv_iter.
module alu_mc
    import alu_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEFAULT,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] oprand1,
    input  logic [XLEN-1:0] oprand2,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            sc_pend_q, sc_pend_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            valid_q, valid_d;
    logic            accept, iter_start, iter_done;
    logic [XLEN-1:0] sc_result, iter_result;
    logic [SH_W-1:0] shamt;

    assign accept     = in_valid && (state_q == IDLE);
    assign iter_start = accept && aluop_is_iter(alu_op);

    alu_muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk_i    (clk),
        .rst_ni   (reset),
        .start_i  (iter_start),
        .op_i     (alu_op),
        .a_i      (oprand1),
        .b_i      (oprand2),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    // Single-cycle ops evaluate the operands captured at accept.
    always_comb begin
        sc_result = '0;
        shamt     = b_q[SH_W-1:0];
        case (op_q)
            ALUOP_ADD:  sc_result = a_q + b_q;
            ALUOP_SUB:  sc_result = a_q - b_q;
            ALUOP_AND:  sc_result = a_q & b_q;
            ALUOP_OR:   sc_result = a_q | b_q;
            ALUOP_XOR:  sc_result = a_q ^ b_q;
            ALUOP_SLL:  sc_result = a_q << shamt;
            ALUOP_SRL:  sc_result = a_q >> shamt;
            ALUOP_SRA:  sc_result = $signed(a_q) >>> shamt;
            ALUOP_SLT:  sc_result = XLEN'($signed(a_q) < $signed(b_q));
            ALUOP_SLTU: sc_result = XLEN'(a_q < b_q);
            ALUOP_NON:  sc_result = '0;
            default:    sc_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        sc_pend_d = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        if (sc_pend_q) begin
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            valid_d  = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (iter_start) begin
                    state_d = CALC;
                end else if (accept) begin
                    sc_pend_d = 1'b1;
                    op_d      = alu_op;
                    a_d       = oprand1;
                    b_d       = oprand2;
                end
            end
            CALC: if (iter_done) state_d = FIX;
            FIX: begin
                result_d = iter_result;
                zero_d   = (iter_result == '0);
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= ALUOP_NON;
            a_q       <= '0;
            b_q       <= '0;
            sc_pend_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sc_pend_q <= sc_pend_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
